// File: rtl/mont_domain_conv.sv
// Bit-serial converter into (x*2^SIZEM mod M) or out of (x*2^-SIZEM mod M) Montgomery form.
// SIZEM clocks per conversion, errors flagged in one; start is ignored while busy, back-to-back accepted in DONE.
module mont_domain_conv #(
  parameter int SIZEM = 8,
  parameter int SIZEI = $clog2(SIZEM + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [SIZEM-1:0] x,
  input  logic [SIZEM-1:0] M,
  output logic [SIZEM-1:0] z,
  output logic             done,
  output logic             busy,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [SIZEM-1:0] acc_q, acc_d;
  logic [SIZEI-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic [SIZEM-1:0] m_q, m_d;
  logic [SIZEM-1:0] z_q, z_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;

  logic [SIZEM:0]   t_enc;
  logic [SIZEM:0]   t_dec;
  logic [SIZEM-1:0] step;
  logic             bad_op;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      m_q     <= '0;
      z_q     <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      m_q     <= m_d;
      z_q     <= z_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  // One reduction step; acc < M is preserved, so no final correction is needed.
  always_comb begin
    t_enc = {acc_q, 1'b0};
    if (t_enc >= {1'b0, m_q}) begin
      t_enc = t_enc - {1'b0, m_q};
    end
    t_dec = {1'b0, acc_q} + (acc_q[0] ? {1'b0, m_q} : '0);
    step  = mode_q ? SIZEM'(t_dec >> 1) : SIZEM'(t_enc);
  end

  assign bad_op = (M == '0) || !M[0] || (x >= M);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    m_d     = m_q;
    z_d     = z_q;
    done_d  = done_q;
    busy_d  = busy_q;
    err_d   = err_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          mode_d = mode;
          m_d    = M;
          acc_d  = x;
          if (bad_op) begin
            z_d     = '0;
            done_d  = 1'b1;
            err_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = DONE;
          end else begin
            cnt_d   = SIZEI'(SIZEM);
            done_d  = 1'b0;
            err_d   = 1'b0;
            busy_d  = 1'b1;
            state_d = RUN;
          end
        end else begin
          done_d  = 1'b0;
          state_d = IDLE;
        end
      end
      RUN: begin
        acc_d = step;
        cnt_d = cnt_q - SIZEI'(1);
        if (cnt_q == SIZEI'(1)) begin
          z_d     = step;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign z    = z_q;
  assign done = done_q;
  assign busy = busy_q;
  assign err  = err_q;

endmodule

// File: tb/tb_mont_domain_conv.sv
// Scoreboard bench for mont_domain_conv: expected results are queued at start and popped on done.
module tb_mont_domain_conv;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         mode;
  logic [W-1:0] x;
  logic [W-1:0] M;
  logic [W-1:0] z;
  logic         done;
  logic         busy;
  logic         err;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [W-1:0] z;
    logic         err;
  } exp_t;

  exp_t sb[$];
  int   dec_seq [8] = '{7, 10, 5, 9, 11, 12, 6, 3};

  mont_domain_conv #(.SIZEM(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .mode (mode),
    .x    (x),
    .M    (M),
    .z    (z),
    .done (done),
    .busy (busy),
    .err  (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Encode by direct modulo; decode by searching for the value whose encoding is x.
  function automatic exp_t model(input logic md, input logic [W-1:0] xv, input logic [W-1:0] mv);
    exp_t e;
    e.z   = '0;
    e.err = 1'b0;
    if (mv == '0 || mv[0] == 1'b0 || xv >= mv) begin
      e.err = 1'b1;
      return e;
    end
    if (!md) begin
      e.z = W'((longint'(xv) << W) % longint'(mv));
    end else begin
      for (int c = 0; c < int'(mv); c++) begin
        if (((longint'(c) << W) % longint'(mv)) == longint'(xv)) e.z = W'(c);
      end
    end
    return e;
  endfunction

  // Called at a negedge; returns at a negedge.
  task automatic do_op(input logic md, input logic [W-1:0] xv, input logic [W-1:0] mv,
                       input int glitch_at, input logic trace, input logic chain, input string tag);
    exp_t e;
    exp_t got;
    int   k;
    int   bcnt;
    e = model(md, xv, mv);
    sb.push_back(e);
    start = 1'b1;
    mode  = md;
    x     = xv;
    M     = mv;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    x     = W'($urandom);
    M     = W'($urandom);
    mode  = ~md;
    k     = 0;
    bcnt  = 0;
    while (!done && k < 40) begin
      if (trace && k >= 1 && k <= 8) check({tag, "_acc"}, 32'(dut.acc_q), dec_seq[k-1]);
      if (busy) bcnt++;
      if (k == glitch_at) begin
        start = 1'b1;
        x     = xv ^ 8'h5A;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    if (trace && k >= 1 && k <= 8) check({tag, "_acc"}, 32'(dut.acc_q), dec_seq[k-1]);
    check({tag, "_done_seen"}, 32'(done), 1);
    check({tag, "_latency"}, k, e.err ? 0 : W);
    check({tag, "_busy_cycles"}, bcnt, e.err ? 0 : W);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 0, 1);
    end else begin
      got = sb.pop_front();
      check({tag, "_z"}, 32'(z), 32'(got.z));
      check({tag, "_err"}, 32'(err), 32'(got.err));
    end
    if (!chain) begin
      @(negedge clk);
      check({tag, "_done_drop"}, 32'(done), 0);
      check({tag, "_z_hold"}, 32'(z), 32'(e.z));
      check({tag, "_err_hold"}, 32'(err), 32'(e.err));
      check({tag, "_busy_idle"}, 32'(busy), 0);
    end
  endtask

  initial begin
    int           dcount;
    logic [W-1:0] mr;
    logic [W-1:0] xr;
    rst_n = 1'b0;
    start = 1'b0;
    mode  = 1'b0;
    x     = '0;
    M     = '0;
    repeat (2) @(negedge clk);
    check("rst_z", 32'(z), 0);
    check("rst_done", 32'(done), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_err", 32'(err), 0);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(1'b0, 8'd5, 8'd13, -1, 1'b0, 1'b0, "enc5");
    do_op(1'b1, 8'd6, 8'd13, -1, 1'b0, 1'b0, "dec6");
    check("dec6_roundtrip", 32'(z), 5);
    do_op(1'b1, 8'd1, 8'd13, -1, 1'b1, 1'b0, "dec1");
    check("dec1_value", 32'(z), 3);
    do_op(1'b0, 8'd12, 8'd13, -1, 1'b0, 1'b0, "enc12");
    check("enc12_value", 32'(z), 4);
    do_op(1'b1, 8'd254, 8'd255, -1, 1'b0, 1'b0, "dec254");
    do_op(1'b0, 8'd0, 8'd1, -1, 1'b0, 1'b0, "m1_enc");
    do_op(1'b1, 8'd0, 8'd1, -1, 1'b0, 1'b0, "m1_dec");

    do_op(1'b0, 8'd3, 8'd12, -1, 1'b0, 1'b0, "err_even");
    do_op(1'b0, 8'd0, 8'd0, -1, 1'b0, 1'b0, "err_zero");
    do_op(1'b0, 8'd13, 8'd13, -1, 1'b0, 1'b0, "err_xge");
    do_op(1'b1, 8'd20, 8'd13, -1, 1'b0, 1'b0, "err_dec");

    do_op(1'b0, 8'd7, 8'd13, 3, 1'b0, 1'b0, "glitch");
    do_op(1'b0, 8'd9, 8'd13, -1, 1'b0, 1'b1, "b2b_a");
    do_op(1'b1, 8'd9, 8'd13, -1, 1'b0, 1'b0, "b2b_b");
    do_op(1'b0, 8'd3, 8'd12, -1, 1'b0, 1'b1, "b2b_err");
    do_op(1'b0, 8'd11, 8'd13, -1, 1'b0, 1'b0, "b2b_after_err");

    // Abort a conversion with a one-cycle reset in the middle of RUN.
    start = 1'b1;
    mode  = 1'b0;
    x     = 8'd5;
    M     = 8'd13;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_z", 32'(z), 0);
    check("abort_done", 32'(done), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_err", 32'(err), 0);
    check("abort_state", 32'(dut.state_q), 0);
    rst_n  = 1'b1;
    dcount = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check("abort_no_done", dcount, 0);
    do_op(1'b0, 8'd5, 8'd13, -1, 1'b0, 1'b0, "after_abort");

    for (int i = 0; i < 8; i++) begin
      mr = {7'($urandom_range(0, 127)), 1'b1};
      xr = W'($urandom_range(0, int'(mr) - 1));
      do_op(1'($urandom_range(0, 1)), xr, mr, -1, 1'b0, 1'b0, "rand");
    end

    check("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
